// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file.
//
// Two writeback requesters (A: ALU, B: load / long-latency return) share the single
// register file write port. Arbitration is round-robin with valid/ready handshakes;
// the chosen request is captured into a registered output stage that drives the write
// port directly. A saturating counter records cycles where both requesters contended.
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   a_valid/a_ready/a_reg/a_data   requester A handshake and payload
//   b_valid/b_ready/b_reg/b_data   requester B handshake and payload
//   flush                          blocks acceptance this cycle, squashes output write
//   write/write_reg/write_data     registered register file write port
//   last_grant                     last requester accepted (0 = A, 1 = B)
//   conflict_cnt                   saturating count of cycles with both valid
module regfile_write_arbiter #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_reg,
  input  logic [N-1:0]     a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_reg,
  input  logic [N-1:0]     b_data,
  input  logic             flush,
  output logic             write,
  output logic [4:0]       write_reg,
  output logic [N-1:0]     write_data,
  output logic             last_grant,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             write_q, write_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [N-1:0]     write_data_q, write_data_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic grant_a, grant_b, contend;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!flush) begin
      if (a_valid && b_valid) begin
        grant_a = last_grant_q;
        grant_b = !last_grant_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign contend = a_valid && b_valid && !flush;

  always_comb begin
    write_d        = 1'b0;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;

    // grant_* already imply valid, so a grant is an accept.
    if (grant_a) begin
      write_d      = (a_reg != 5'd0);  // x0 is accepted but never written
      write_reg_d  = a_reg;
      write_data_d = a_data;
      last_grant_d = 1'b0;
    end else if (grant_b) begin
      write_d      = (b_reg != 5'd0);
      write_reg_d  = b_reg;
      write_data_d = b_data;
      last_grant_d = 1'b1;
    end

    if (contend && (conflict_cnt_q != CntMax)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q        <= 1'b0;
      write_reg_q    <= 5'd0;
      write_data_q   <= '0;
      last_grant_q   <= 1'b1;  // A wins the first tie
      conflict_cnt_q <= '0;
    end else begin
      write_q        <= write_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign write        = write_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign last_grant   = last_grant_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a directed vector table, hand-written reset and
// saturation sequences, and randomized traffic checked against a behavioural model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, flush;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, write, last_grant;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [7:0]  conflict_cnt;

  // Narrow-counter instance sharing the same inputs, for saturation checks.
  logic        a_ready3, b_ready3, write3, last_grant3;
  logic [4:0]  write_reg3;
  logic [31:0] write_data3;
  logic [2:0]  conflict_cnt3;

  regfile_write_arbiter #(.N(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .flush(flush),
    .write(write), .write_reg(write_reg), .write_data(write_data),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  regfile_write_arbiter #(.N(32), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready3), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready3), .b_reg(b_reg), .b_data(b_data),
    .flush(flush),
    .write(write3), .write_reg(write_reg3), .write_data(write_data3),
    .last_grant(last_grant3), .conflict_cnt(conflict_cnt3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: what the write port and counters should show.
  logic        m_write, m_lg;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_cnt, m_cnt3;

  task automatic model_reset();
    m_write = 0; m_reg = 0; m_data = 0; m_lg = 1; m_cnt = 0; m_cnt3 = 0;
  endtask

  // Who should be served right now, from the arbitration rules.
  task automatic model_grant(output logic ga, output logic gb);
    ga = 0; gb = 0;
    if (flush) return;
    if (a_valid && b_valid) begin
      if (m_lg == 1'b1) ga = 1; else gb = 1;  // not the last winner
    end else if (a_valid) ga = 1;
    else if (b_valid) gb = 1;
  endtask

  task automatic model_edge(input logic ga, input logic gb);
    if (ga) begin
      m_write = (a_reg != 0); m_reg = a_reg; m_data = a_data; m_lg = 0;
    end else if (gb) begin
      m_write = (b_reg != 0); m_reg = b_reg; m_data = b_data; m_lg = 1;
    end else begin
      m_write = 0;
    end
    if (a_valid && b_valid && !flush) begin
      m_cnt  = (m_cnt  >= 255) ? 255 : m_cnt + 1;
      m_cnt3 = (m_cnt3 >= 7)   ? 7   : m_cnt3 + 1;
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".write"},      write,         m_write);
    chk({tag, ".write_reg"},  write_reg,     m_reg);
    chk({tag, ".write_data"}, write_data,    m_data);
    chk({tag, ".last_grant"}, last_grant,    m_lg);
    chk({tag, ".cnt"},        conflict_cnt,  m_cnt);
    chk({tag, ".cnt3"},       conflict_cnt3, m_cnt3);
  endtask

  // Inputs are already applied (at posedge+1); check readies, clock, check outputs.
  task automatic step_model(input string tag, output logic ga, output logic gb);
    #3;
    model_grant(ga, gb);
    chk({tag, ".a_ready"}, a_ready, ga);
    chk({tag, ".b_ready"}, b_ready, gb);
    @(posedge clk);
    model_edge(ga, gb);
    #1;
    chk_outputs(tag);
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; flush = 0;
    a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    model_reset();
  endtask

  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic bv; logic [4:0] br; logic [31:0] bd;
    logic fl;
    logic ea; logic eb;
    logic ew; logic [4:0] ereg; logic [31:0] edata; logic elg; logic [7:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic bv, input logic [4:0] br, input logic [31:0] bd,
                              input logic fl, input logic ea, input logic eb,
                              input logic ew, input logic [4:0] ereg,
                              input logic [31:0] edata, input logic elg,
                              input logic [7:0] ecnt);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd; v.fl = fl;
    v.ea = ea; v.eb = eb; v.ew = ew; v.ereg = ereg; v.edata = edata; v.elg = elg;
    v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    logic ga, gb;
    logic [7:0] c3;

    // Directed table, applied straight after reset (last_grant=1 -> A wins first tie).
    tbl[0] = mk(1, 1, 32'h11, 1, 2, 32'h22, 0,  1, 0,  1, 1, 32'h11, 0, 1);
    tbl[1] = mk(1, 1, 32'h11, 1, 2, 32'h22, 0,  0, 1,  1, 2, 32'h22, 1, 2);
    tbl[2] = mk(1, 1, 32'h11, 1, 2, 32'h22, 0,  1, 0,  1, 1, 32'h11, 0, 3);
    tbl[3] = mk(1, 1, 32'h11, 1, 2, 32'h22, 0,  0, 1,  1, 2, 32'h22, 1, 4);
    tbl[4] = mk(0, 0, 32'h0,  0, 0, 32'h0,  0,  0, 0,  0, 2, 32'h22, 1, 4);
    tbl[5] = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0, 0, 1, 0, 1, 5, 32'hDEADBEEF, 0, 4);
    tbl[6] = mk(0, 0, 32'h0,  0, 0, 32'h0,  0,  0, 0,  0, 5, 32'hDEADBEEF, 0, 4);
    tbl[7] = mk(0, 0, 32'h0,  1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 1, 4);
    tbl[8] = mk(1, 3, 32'h33, 1, 4, 32'h44, 1,  0, 0,  0, 0, 32'hFFFFFFFF, 1, 4);
    tbl[9] = mk(1, 3, 32'h33, 1, 4, 32'h44, 0,  1, 0,  1, 3, 32'h33, 0, 5);

    rst = 1;
    idle_inputs();
    #2;
    do_reset();
    chk("reset.write", write, 0);
    chk("reset.write_reg", write_reg, 0);
    chk("reset.write_data", write_data, 0);
    chk("reset.last_grant", last_grant, 1);
    chk("reset.cnt", conflict_cnt, 0);

    for (int i = 0; i < 10; i++) begin
      a_valid = tbl[i].av; a_reg = tbl[i].ar; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_reg = tbl[i].br; b_data = tbl[i].bd;
      flush = tbl[i].fl;
      #3;
      chk($sformatf("tbl%0d.a_ready", i), a_ready, tbl[i].ea);
      chk($sformatf("tbl%0d.b_ready", i), b_ready, tbl[i].eb);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.write", i), write, tbl[i].ew);
      chk($sformatf("tbl%0d.write_reg", i), write_reg, tbl[i].ereg);
      chk($sformatf("tbl%0d.write_data", i), write_data, tbl[i].edata);
      chk($sformatf("tbl%0d.last_grant", i), last_grant, tbl[i].elg);
      chk($sformatf("tbl%0d.cnt", i), conflict_cnt, tbl[i].ecnt);
      c3 = (tbl[i].ecnt > 7) ? 8'd7 : tbl[i].ecnt;
      chk($sformatf("tbl%0d.cnt3", i), conflict_cnt3, c3);
    end

    // Saturation of the 3-bit counter over 10 conflict cycles.
    do_reset();
    a_valid = 1; a_reg = 6; a_data = 32'hA6;
    b_valid = 1; b_reg = 7; b_data = 32'hB7;
    for (int i = 0; i < 10; i++) begin
      step_model($sformatf("sat%0d", i), ga, gb);
      c3 = (i + 1 > 7) ? 8'd7 : 8'(i + 1);
      chk($sformatf("sat%0d.cnt3_abs", i), conflict_cnt3, c3);
    end

    // Asynchronous reset with a write in flight; B stays pending and is re-presented.
    do_reset();
    a_valid = 1; a_reg = 9; a_data = 32'h99;
    b_valid = 1; b_reg = 10; b_data = 32'hAA;
    step_model("inflight", ga, gb);
    chk("inflight.write_pre", write, 1);
    a_valid = 0;
    #2;
    rst = 0;
    #1;
    chk("async.write", write, 0);
    chk("async.cnt", conflict_cnt, 0);
    chk("async.last_grant", last_grant, 1);
    chk("async.write_reg", write_reg, 0);
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    step_model("represent", ga, gb);
    chk("represent.b_ready", gb, 1);
    chk("represent.write_reg_abs", write_reg, 10);
    b_valid = 0;
    step_model("represent_idle", ga, gb);

    // Randomized traffic; requesters hold payload until accepted.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!a_valid) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_reg   = 5'($urandom_range(0, 6));
        a_data  = $urandom;
      end
      if (!b_valid) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_reg   = 5'($urandom_range(0, 6));
        b_data  = $urandom;
      end
      flush = ($urandom_range(0, 7) == 0);
      step_model("rand", ga, gb);
      if (ga) a_valid = 0;
      if (gb) b_valid = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
